neureka_tcdm_rr_arbiter: RTL and testbench

- Shares one wide HCI-style TCDM master port between N_REQ requesters, e.g. the activation streamer and the weight loader.
- Lets the weight traffic use the main port instead of a dedicated weight port.
- Round-robin arbitration with request locking (no mid-transaction switch).
- A response-routing FIFO tracks outstanding reads and returns each r_valid to the requester that issued it.
- Sits between the NEUREKA streamers and the wide TCDM port.

---
 rtl/neureka_tcdm_rr_arbiter_if.sv | 32 +++
 rtl/neureka_tcdm_rr_arbiter.sv | 61 ++++++
 tb/tb_neureka_tcdm_rr_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/neureka_tcdm_rr_arbiter_if.sv
// neureka_tcdm_rr_arbiter_if: requester-side and master-side TCDM bus bundle of the arbiter
interface neureka_tcdm_rr_arbiter_if #(
  parameter int BW    = 256,
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]             in_req;
  logic [N_REQ-1:0]             in_gnt;
  logic [N_REQ-1:0][31:0]       in_add;
  logic [N_REQ-1:0]             in_wen;
  logic [N_REQ-1:0][BW/8-1:0]   in_be;
  logic [N_REQ-1:0][BW-1:0]     in_data;
  logic [BW-1:0]                in_r_data;
  logic [N_REQ-1:0]             in_r_valid;
  logic                         out_req;
  logic                         out_gnt;
  logic [31:0]                  out_add;
  logic                         out_wen;
  logic [BW/8-1:0]              out_be;
  logic [BW-1:0]                out_data;
  logic [BW-1:0]                out_r_data;
  logic                         out_r_valid;
  logic                         busy;
  logic                         err;
  modport slave (
    input  in_req, in_add, in_wen, in_be, in_data, out_gnt, out_r_data, out_r_valid,
    output in_gnt, in_r_data, in_r_valid, out_req, out_add, out_wen, out_be, out_data, busy, err
  );
  modport master (
    output in_req, in_add, in_wen, in_be, in_data, out_gnt, out_r_data, out_r_valid,
    input  in_gnt, in_r_data, in_r_valid, out_req, out_add, out_wen, out_be, out_data, busy, err
  );
endinterface

// File: rtl/neureka_tcdm_rr_arbiter.sv
// neureka_tcdm_rr_arbiter: round-robin sharing of one TCDM master port with locking and read-response routing
module neureka_tcdm_rr_arbiter #(
  parameter int BW        = 256,
  parameter int N_REQ     = 2,
  parameter int MAX_OUTST = 4
) (
  input logic clk_i,
  input logic rst_ni,
  input logic clear_i,
  neureka_tcdm_rr_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int AW = $clog2(MAX_OUTST);
  logic [IW-1:0] ptr, lock_idx, winner;
  logic          lock, err, full, stall, hs, push, pop;
  logic [IW-1:0] fifo [MAX_OUTST];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  // first requester at or after the pointer wins, unless a presented request is still locked
  always_comb begin
    winner = ptr;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (bus.in_req[(int'(ptr) + k) % N_REQ]) winner = IW'((int'(ptr) + k) % N_REQ);
    if (lock) winner = lock_idx;
  end
  assign full  = cnt == (AW+1)'(MAX_OUTST);
  assign stall = full & bus.in_wen[winner] & ~lock;
  assign hs    = bus.out_req & bus.out_gnt;
  assign push  = hs & bus.in_wen[winner];
  assign pop   = bus.out_r_valid & (cnt != '0);
  assign bus.out_req    = bus.in_req[winner] & ~stall;
  assign bus.out_add    = bus.in_add[winner];
  assign bus.out_wen    = bus.in_wen[winner];
  assign bus.out_be     = bus.in_be[winner];
  assign bus.out_data   = bus.in_data[winner];
  assign bus.in_gnt     = N_REQ'(hs) << winner;
  assign bus.in_r_valid = N_REQ'(pop) << fifo[rptr];
  assign bus.in_r_data  = bus.out_r_data;
  assign bus.busy       = |bus.in_req | (cnt != '0) | lock;
  assign bus.err        = err;
  // pointer, lock, FIFO bookkeeping and sticky error; clear outranks any same-cycle push/pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr <= '0; lock <= 1'b0; lock_idx <= '0; wptr <= '0; rptr <= '0; cnt <= '0; err <= 1'b0;
    end else if (clear_i) begin
      ptr <= '0; lock <= 1'b0; lock_idx <= '0; wptr <= '0; rptr <= '0; cnt <= '0; err <= 1'b0;
    end else begin
      lock     <= bus.out_req & ~bus.out_gnt;
      lock_idx <= winner;
      if (hs) ptr <= (winner == IW'(N_REQ - 1)) ? '0 : winner + IW'(1);
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      err <= err | (bus.out_r_valid & (cnt == '0));
    end
  end
  // routing entries are only meaningful while counted, so they need no reset
  always_ff @(posedge clk_i) begin
    if (push) fifo[wptr] <= winner;
  end
endmodule

// File: tb/tb_neureka_tcdm_rr_arbiter.sv
// tb_neureka_tcdm_rr_arbiter: directed vector table plus async-reset sequence for the TCDM arbiter
module tb_neureka_tcdm_rr_arbiter;
  localparam int BW = 64;
  typedef struct packed {
    logic [1:0] req, wen;
    logic       gnt, rv, clr;
    logic       oreq;
    logic [1:0] igt, irv;
    logic       aw, busy, err;
  } vec_t;
  logic clk = 1'b0, rst_ni = 1'b0, clear_i = 1'b0;
  int checks = 0, failures = 0;
  logic [31:0]   add_c  [2] = '{32'h0000_1000, 32'h0000_2000};
  logic [BW-1:0] data_c [2] = '{64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210};
  logic [7:0]    be_c   [2] = '{8'h0f, 8'hf0};
  logic [BW-1:0] rdata_c = 64'h5a5a_0000_ffff_a5a5;
  vec_t tv[$];
  neureka_tcdm_rr_arbiter_if #(.BW(BW), .N_REQ(2)) bus ();
  neureka_tcdm_rr_arbiter #(.BW(BW), .N_REQ(2), .MAX_OUTST(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [1:0] req, input logic [1:0] wen, input logic gnt, input logic rv, input logic clr);
    bus.in_req = req; bus.in_wen = wen; bus.out_gnt = gnt; bus.out_r_valid = rv; clear_i = clr;
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      bus.in_add[i] = add_c[i]; bus.in_data[i] = data_c[i]; bus.in_be[i] = be_c[i];
    end
    bus.out_r_data = rdata_c;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    //                  req wen g r c o igt irv a b e
    // two readers, gnt every cycle, one-cycle responses
    tv.push_back(vec_t'(15'b11_11_1_0_0_1_01_00_0_1_0));
    tv.push_back(vec_t'(15'b11_11_1_1_0_1_10_01_1_1_0));
    tv.push_back(vec_t'(15'b11_11_1_1_0_1_01_10_0_1_0));
    tv.push_back(vec_t'(15'b11_11_1_1_0_1_10_01_1_1_0));
    tv.push_back(vec_t'(15'b00_11_1_1_0_0_00_10_0_1_0));
    tv.push_back(vec_t'(15'b00_11_1_0_0_0_00_00_0_0_0));
    // gnt withheld three cycles: req0 locked, req1 waits
    tv.push_back(vec_t'(15'b01_11_0_0_0_1_00_00_0_1_0));
    tv.push_back(vec_t'(15'b11_11_0_0_0_1_00_00_0_1_0));
    tv.push_back(vec_t'(15'b11_11_0_0_0_1_00_00_0_1_0));
    tv.push_back(vec_t'(15'b11_11_1_0_0_1_01_00_0_1_0));
    tv.push_back(vec_t'(15'b10_11_1_1_0_1_10_01_1_1_0));
    tv.push_back(vec_t'(15'b00_11_0_1_0_0_00_10_0_1_0));
    tv.push_back(vec_t'(15'b00_11_0_0_0_0_00_00_0_0_0));
    // fill the FIFO with req0 reads; req1 write still passes; reads stall until a pop
    tv.push_back(vec_t'(15'b01_11_1_0_0_1_01_00_0_1_0));
    tv.push_back(vec_t'(15'b01_11_1_0_0_1_01_00_0_1_0));
    tv.push_back(vec_t'(15'b01_11_1_0_0_1_01_00_0_1_0));
    tv.push_back(vec_t'(15'b01_11_1_0_0_1_01_00_0_1_0));
    tv.push_back(vec_t'(15'b11_01_1_0_0_1_10_00_1_1_0));
    tv.push_back(vec_t'(15'b01_01_1_0_0_0_00_00_0_1_0));
    tv.push_back(vec_t'(15'b01_01_1_1_0_0_00_01_0_1_0));
    tv.push_back(vec_t'(15'b01_01_1_0_0_1_01_00_0_1_0));
    // full again: stall, then push and pop together, then drain mixed routing 0,0,0,1,0
    tv.push_back(vec_t'(15'b10_10_1_1_0_0_00_01_1_1_0));
    tv.push_back(vec_t'(15'b10_10_1_1_0_1_10_01_1_1_0));
    tv.push_back(vec_t'(15'b01_01_1_1_0_1_01_01_0_1_0));
    tv.push_back(vec_t'(15'b00_00_0_1_0_0_00_01_0_1_0));
    tv.push_back(vec_t'(15'b00_00_0_1_0_0_00_10_0_1_0));
    tv.push_back(vec_t'(15'b00_00_0_1_0_0_00_01_0_1_0));
    tv.push_back(vec_t'(15'b00_00_0_0_0_0_00_00_0_0_0));
    // response with empty FIFO: sticky err, then clear resets err and pointer
    tv.push_back(vec_t'(15'b00_00_0_1_0_0_00_00_0_0_0));
    tv.push_back(vec_t'(15'b00_00_0_0_0_0_00_00_0_0_1));
    tv.push_back(vec_t'(15'b00_00_0_0_0_0_00_00_0_0_1));
    tv.push_back(vec_t'(15'b00_00_0_0_1_0_00_00_0_0_1));
    tv.push_back(vec_t'(15'b11_00_1_0_0_1_01_00_0_1_0));
    tv.push_back(vec_t'(15'b00_00_0_0_0_0_00_00_0_0_0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_req", 64'(bus.out_req), 64'd0);
    chk("reset in_gnt", 64'(bus.in_gnt), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset err", 64'(bus.err), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].req, tv[i].wen, tv[i].gnt, tv[i].rv, tv[i].clr);
      @(negedge clk);
      chk($sformatf("row%0d out_req", i), 64'(bus.out_req), 64'(tv[i].oreq));
      chk($sformatf("row%0d in_gnt", i), 64'(bus.in_gnt), 64'(tv[i].igt));
      chk($sformatf("row%0d in_r_valid", i), 64'(bus.in_r_valid), 64'(tv[i].irv));
      chk($sformatf("row%0d busy", i), 64'(bus.busy), 64'(tv[i].busy));
      chk($sformatf("row%0d err", i), 64'(bus.err), 64'(tv[i].err));
      chk($sformatf("row%0d in_r_data", i), 64'(bus.in_r_data), 64'(rdata_c));
      if (tv[i].oreq) begin
        chk($sformatf("row%0d out_add", i), 64'(bus.out_add), 64'(add_c[tv[i].aw]));
        chk($sformatf("row%0d out_data", i), 64'(bus.out_data), 64'(data_c[tv[i].aw]));
        chk($sformatf("row%0d out_be", i), 64'(bus.out_be), 64'(be_c[tv[i].aw]));
        chk($sformatf("row%0d out_wen", i), 64'(bus.out_wen), 64'(tv[i].wen[tv[i].aw]));
      end
      @(posedge clk); #1;
    end
    // three reads outstanding plus a locked fourth, then async reset between edges
    drive(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    bus.out_gnt = 1'b0;
    @(negedge clk);
    chk("pre-rst out_req", 64'(bus.out_req), 64'd1);
    chk("pre-rst busy", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    rst_ni = 1'b0;
    drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    #1;
    chk("async-rst out_req", 64'(bus.out_req), 64'd0);
    chk("async-rst busy", 64'(bus.busy), 64'd0);
    chk("async-rst in_r_valid", 64'(bus.in_r_valid), 64'd0);
    chk("async-rst err", 64'(bus.err), 64'd0);
    bus.out_r_valid = 1'b0;
    #1 rst_ni = 1'b1;
    drive(2'b10, 2'b10, 1'b1, 1'b0, 1'b0);
    #1;
    chk("post-rst out_req", 64'(bus.out_req), 64'd1);
    chk("post-rst in_gnt", 64'(bus.in_gnt), 64'd2);
    chk("post-rst out_add", 64'(bus.out_add), 64'(add_c[1]));
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("post-rst in_r_valid", 64'(bus.in_r_valid), 64'd2);
    chk("post-rst busy", 64'(bus.busy), 64'd1);
    @(posedge clk); #1;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("final busy", 64'(bus.busy), 64'd0);
    chk("final err", 64'(bus.err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
